// File: rtl/blink_pkg.sv
// Shared constants for the Blink RTC block: I/O port map and TSTA bit positions.
package blink_pkg;

  localparam logic [7:0] PORT_TACK = 8'hB4;
  localparam logic [7:0] PORT_TSTA = 8'hB5;
  localparam logic [7:0] PORT_TMK  = 8'hB5;
  localparam logic [7:0] PORT_TIM0 = 8'hD0;
  localparam logic [7:0] PORT_TIM1 = 8'hD1;
  localparam logic [7:0] PORT_TIM2 = 8'hD2;
  localparam logic [7:0] PORT_TIM3 = 8'hD3;
  localparam logic [7:0] PORT_TIM4 = 8'hD4;
  localparam logic [7:0] PORT_ALM0 = 8'hD5;
  localparam logic [7:0] PORT_ALM1 = 8'hD6;
  localparam logic [7:0] PORT_ALM2 = 8'hD7;

  localparam int unsigned TSTA_TICK = 0;
  localparam int unsigned TSTA_SEC  = 1;
  localparam int unsigned TSTA_MIN  = 2;
  localparam int unsigned TSTA_ALM  = 3;

endpackage

// File: rtl/rtc_stat_bit.sv
// Sticky status flag: set has priority over clear so an event coinciding
// with an acknowledge is never lost.
module rtc_stat_bit (
  input  logic mck,
  input  logic rin_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge mck) begin
    if (!rin_n)   q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end

endmodule

// File: rtl/blink_rtc.sv
// Blink real-time clock: tick prescaler, TIM0-TIM4 time counters, TSTA/TMK
// status and mask, one-shot minute alarm, on the Z80 I/O register bus.
module blink_rtc
  import blink_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 49152,
  parameter int unsigned TICKS_PER_SEC = 200,
  parameter int unsigned SEC_PER_MIN   = 60,
  parameter int unsigned MIN_W         = 21,
  parameter int unsigned ALARM_EN      = 1
) (
  input  logic       mck,
  input  logic       rin_n,
  input  logic       flp,
  input  logic       restim,
  input  logic [7:0] ca,
  input  logic [7:0] cdi,
  input  logic       ior_n,
  input  logic       crd_n,
  output logic [7:0] rdata,
  output logic       rhit,
  output logic [3:0] tsta,
  output logic       rtc_int
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICKS_PER_SEC > 256 || SEC_PER_MIN > 64 || MIN_W < 17 || MIN_W > 24) begin : g_param_err
    $error("blink_rtc: TICKS_PER_SEC<=256, SEC_PER_MIN<=64, MIN_W in 17..24 required");
  end

  logic [PW-1:0]    presc;
  logic [7:0]       tim0, tim1, sh_tim1;
  logic [MIN_W-1:0] timm, sh_timm, timm_nxt;
  logic [23:0]      sh_timm_ext;
  logic [3:0]       tmk, set_vec, clr_vec;
  logic             io_rd, io_wr, io_rd_d, io_wr_d, rd_p, wr_p;
  logic             hold, tick, sec_wrap, min_wrap, alm_hit;
  logic             rd_hit;
  logic [7:0]       rd_val;

  // Strobes are edge-qualified so a long I/O cycle produces a single access.
  assign io_rd = !ior_n && !crd_n;
  assign io_wr = !ior_n &&  crd_n;
  assign rd_p  = rin_n && io_rd && !io_rd_d;
  assign wr_p  = rin_n && io_wr && !io_wr_d;

  assign hold     = (!rin_n && flp) || restim;
  assign tick     = !hold && (presc == PW'(TICK_DIV - 1));
  assign sec_wrap = tick && (tim0 == 8'(TICKS_PER_SEC - 1));
  assign min_wrap = sec_wrap && (tim1 == 8'(SEC_PER_MIN - 1));
  assign timm_nxt = timm + 1'b1;

  always_ff @(posedge mck) begin
    if (hold) begin
      presc   <= '0;
      tim0    <= '0;
      tim1    <= '0;
      timm    <= '0;
      sh_tim1 <= '0;
      sh_timm <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)     tim0 <= sec_wrap ? '0 : tim0 + 1'b1;
      if (sec_wrap) tim1 <= min_wrap ? '0 : tim1 + 1'b1;
      if (min_wrap) timm <= timm_nxt;
      // TIM0 read freezes the upper bytes so a multi-byte read is coherent.
      if (rd_p && ca == PORT_TIM0) begin
        sh_tim1 <= tim1;
        sh_timm <= timm;
      end
    end
  end

  if (ALARM_EN != 0) begin : g_alarm
    logic [MIN_W-1:0] alm;
    logic             armed;

    assign alm_hit = min_wrap && armed && (timm_nxt == alm);

    always_ff @(posedge mck) begin
      if (!rin_n) begin
        alm   <= '0;
        armed <= 1'b0;
      end else begin
        if (wr_p) begin
          case (ca)
            PORT_ALM0: alm[7:0]        <= cdi;
            PORT_ALM1: alm[15:8]       <= cdi;
            PORT_ALM2: alm[MIN_W-1:16] <= cdi[MIN_W-17:0];
            default: ;
          endcase
        end
        if (wr_p && ca == PORT_ALM2)                              armed <= 1'b1;
        else if (wr_p && (ca == PORT_ALM0 || ca == PORT_ALM1))    armed <= 1'b0;
        else if (alm_hit)                                         armed <= 1'b0;
      end
    end
  end else begin : g_no_alarm
    assign alm_hit = 1'b0;
  end

  always_comb begin
    set_vec            = '0;
    set_vec[TSTA_TICK] = tick;
    set_vec[TSTA_SEC]  = sec_wrap;
    set_vec[TSTA_MIN]  = min_wrap;
    set_vec[TSTA_ALM]  = alm_hit;
    clr_vec            = (wr_p && ca == PORT_TACK) ? cdi[3:0] : '0;
  end

  for (genvar i = 0; i < 4; i++) begin : g_stat
    rtc_stat_bit u_stat (
      .mck  (mck),
      .rin_n(rin_n),
      .set  (set_vec[i]),
      .clr  (clr_vec[i]),
      .q    (tsta[i])
    );
  end

  assign rtc_int = |(tsta & tmk);

  always_comb begin
    sh_timm_ext              = '0;
    sh_timm_ext[MIN_W-1:0]   = sh_timm;
  end

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (ca)
      PORT_TSTA: rd_val = {4'b0, tsta};
      PORT_TIM0: rd_val = tim0;
      PORT_TIM1: rd_val = {2'b0, sh_tim1[5:0]};
      PORT_TIM2: rd_val = sh_timm_ext[7:0];
      PORT_TIM3: rd_val = sh_timm_ext[15:8];
      PORT_TIM4: rd_val = sh_timm_ext[23:16];
      default:   rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      io_rd_d <= 1'b0;
      io_wr_d <= 1'b0;
      tmk     <= '0;
      rdata   <= '0;
      rhit    <= 1'b0;
    end else begin
      io_rd_d <= io_rd;
      io_wr_d <= io_wr;
      if (wr_p && ca == PORT_TMK) tmk <= cdi[3:0];
      rhit <= rd_p && rd_hit;
      if (rd_p && rd_hit) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_blink_rtc.sv
// Scoreboarded bench for blink_rtc; reference time is derived from elapsed
// cycles since the counters were last zeroed.
module tb_blink_rtc;
  import blink_pkg::*;

  localparam int unsigned TD  = 4;
  localparam int unsigned TPS = 3;
  localparam int unsigned SPM = 2;
  localparam int unsigned MW  = 17;

  logic       mck, rin_n, flp, restim, ior_n, crd_n;
  logic [7:0] ca, cdi, rdata;
  logic       rhit, rtc_int;
  logic [3:0] tsta;

  blink_rtc #(
    .TICK_DIV     (TD),
    .TICKS_PER_SEC(TPS),
    .SEC_PER_MIN  (SPM),
    .MIN_W        (MW),
    .ALARM_EN     (1)
  ) dut (
    .mck    (mck),
    .rin_n  (rin_n),
    .flp    (flp),
    .restim (restim),
    .ca     (ca),
    .cdi    (cdi),
    .ior_n  (ior_n),
    .crd_n  (crd_n),
    .rdata  (rdata),
    .rhit   (rhit),
    .tsta   (tsta),
    .rtc_int(rtc_int)
  );

  initial mck = 1'b0;
  always #5 mck = ~mck;

  int unsigned cyc;
  logic [3:0]  m_tsta, m_tmk;
  logic [16:0] m_alm, m_shm;
  logic [7:0]  m_sh1;
  bit          m_armed, pls_wr, rd_pending;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_rd;
  int          checks, failures;

  function automatic int unsigned m_tim0();
    return (cyc / TD) % TPS;
  endfunction
  function automatic int unsigned m_tim1();
    return (cyc / (TD * TPS)) % SPM;
  endfunction
  function automatic logic [16:0] m_timm();
    return 17'((cyc / (TD * TPS * SPM)) % (1 << MW));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock edge: advance the reference and compare status outputs.
  task automatic step();
    bit hard, tick, secw, minw, fire;
    int unsigned t;
    logic [16:0] ntm;
    @(posedge mck);
    hard = !rin_n && flp;
    tick = !hard && !restim && (cyc % TD == TD - 1);
    if (hard || restim) begin
      cyc = 0; m_sh1 = '0; m_shm = '0;
    end else cyc++;
    t    = cyc / TD;
    secw = tick && (t % TPS == 0);
    minw = tick && (t % (TPS * SPM) == 0);
    ntm  = m_timm();
    fire = minw && m_armed && (ntm == m_alm);
    if (!rin_n) begin
      m_tsta = '0; m_tmk = '0; m_alm = '0; m_armed = 0;
    end else begin
      if (fire) m_armed = 0;
      if (pls_wr) begin
        case (ca)
          PORT_TACK: m_tsta = m_tsta & ~cdi[3:0];
          PORT_TMK:  m_tmk = cdi[3:0];
          PORT_ALM0: begin m_alm[7:0] = cdi; m_armed = 0; end
          PORT_ALM1: begin m_alm[15:8] = cdi; m_armed = 0; end
          PORT_ALM2: begin m_alm[16] = cdi[0]; m_armed = 1; end
          default: ;
        endcase
      end
      m_tsta = m_tsta | {fire, minw, secw, tick};
    end
    pls_wr = 0;
    @(negedge mck);
    #1;
    chk("tsta", tsta, m_tsta);
    chk("rtc_int", rtc_int, |(m_tsta & m_tmk));
  endtask

  task automatic io_begin(input bit rd, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] e;
    bit hit;
    ca = a; cdi = d; ior_n = 1'b0; crd_n = !rd;
    rd_pending = 0;
    if (!rd) pls_wr = 1;
    else begin
      hit = 1; e = '0;
      case (a)
        PORT_TSTA: e = {4'b0, m_tsta};
        PORT_TIM0: begin e = 8'(m_tim0()); m_sh1 = 8'(m_tim1()); m_shm = m_timm(); end
        PORT_TIM1: e = m_sh1;
        PORT_TIM2: e = m_shm[7:0];
        PORT_TIM3: e = m_shm[15:8];
        PORT_TIM4: e = {7'b0, m_shm[16]};
        default:   hit = 0;
      endcase
      if (hit) begin exp_q.push_back(e); rd_pending = 1; end
    end
  endtask

  task automatic io_end();
    ior_n = 1'b1; crd_n = 1'b1;
    step();
    if (rd_pending) chk("read_answered", exp_q.size(), 0);
    rd_pending = 0;
  endtask

  task automatic io(input bit rd, input logic [7:0] a, input logic [7:0] d, input int unsigned len);
    io_begin(rd, a, d);
    for (int unsigned i = 0; i < len; i++) step();
    io_end();
  endtask

  always @(negedge mck) begin
    if (rhit === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rhit_unexpected: actual=1 required=0 at %0t", $time);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
        last_rd = rdata;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] rd_addrs[9] = '{PORT_TSTA, PORT_TIM0, PORT_TIM1, PORT_TIM2, PORT_TIM3,
                              PORT_TIM4, PORT_TACK, 8'h00, 8'hD8};
  logic [7:0] wr_addrs[7] = '{PORT_TACK, PORT_TMK, PORT_ALM0, PORT_ALM1, PORT_ALM2,
                              PORT_TIM0, 8'h3C};

  initial begin
    checks = 0; failures = 0;
    cyc = 0; m_tsta = '0; m_tmk = '0; m_alm = '0; m_shm = '0; m_sh1 = '0;
    m_armed = 0; pls_wr = 0; rd_pending = 0; last_rd = '0;
    rin_n = 1'b0; flp = 1'b1; restim = 1'b0;
    ca = '0; cdi = '0; ior_n = 1'b1; crd_n = 1'b1;

    step(); step();
    chk("rst_rdata", rdata, 0);
    chk("rst_rhit", rhit, 0);
    rin_n = 1'b1;

    // Ticks and wraps from a hard reset; TIM0 sampled once per tick period.
    for (int i = 0; i < 4; i++) begin
      step(); step();
      io(1, PORT_TIM0, 8'h00, 1);
    end
    for (int i = 0; i < 30 && cyc < 24; i++) step();
    chk("min_flag", tsta[TSTA_MIN], 1);
    io(1, PORT_TIM0, 8'h00, 1);
    io(1, PORT_TIM2, 8'h00, 1);
    chk("timm_one", last_rd, 8'h01);

    // Long acknowledge strobe whose first edge lands on a tick.
    for (int i = 0; i < 8 && (cyc % TD) != TD - 1; i++) step();
    io_begin(0, PORT_TACK, 8'h01);
    step();
    chk("clr_vs_tick", tsta[TSTA_TICK], 1);
    for (int i = 0; i < 9; i++) step();
    io_end();
    for (int i = 0; i < 8 && (cyc % TD) != 0; i++) step();
    io_begin(0, PORT_TACK, 8'h01);
    step();
    chk("clr_tick", tsta[TSTA_TICK], 0);
    io_end();

    // Second-wrap interrupt and its acknowledge.
    io(0, PORT_TACK, 8'h0F, 1);
    io(0, PORT_TMK, 8'h02, 1);
    for (int i = 0; i < 40 && rtc_int !== 1'b1; i++) step();
    chk("sec_int", rtc_int, 1);
    io_begin(0, PORT_TACK, 8'h02);
    step();
    chk("sec_int_ack", rtc_int, 0);
    io_end();

    // restim zeroes the counters but keeps the flags.
    restim = 1'b1;
    io(1, PORT_TIM0, 8'h00, 1);
    io(1, PORT_TIM1, 8'h00, 1);
    io(1, PORT_TIM2, 8'h00, 1);
    chk("restim_timm", last_rd, 0);
    restim = 1'b0;

    // Alarm at minute 3, then confirm it is one-shot.
    io(0, PORT_ALM0, 8'h03, 1);
    io(0, PORT_ALM1, 8'h00, 1);
    io(0, PORT_ALM2, 8'h00, 1);
    io(0, PORT_TACK, 8'h0F, 1);
    io(0, PORT_TMK, 8'h08, 1);
    for (int i = 0; i < 200 && m_timm() != 3; i++) step();
    chk("alarm_flag", tsta[TSTA_ALM], 1);
    chk("alarm_int", rtc_int, 1);
    io(0, PORT_TACK, 8'h08, 1);
    restim = 1'b1; step(); step(); restim = 1'b0;
    for (int i = 0; i < 120; i++) step();
    chk("alarm_oneshot", tsta[TSTA_ALM], 0);

    // Snapshot straddling the 255 -> 256 minute wrap.
    for (int i = 0; i < 8000 && !(m_timm() == 17'd255 && m_tim1() == SPM - 1 &&
         m_tim0() == TPS - 1 && (cyc % TD) == TD - 2); i++) step();
    io(1, PORT_TIM0, 8'h00, 1);
    io(1, PORT_TIM2, 8'h00, 1);
    chk("snap_lo", last_rd, 8'hFF);
    io(1, PORT_TIM3, 8'h00, 1);
    chk("snap_hi", last_rd, 8'h00);

    // Soft reset at minute 5 keeps time running.
    restim = 1'b1; step(); restim = 1'b0;
    io(0, PORT_TMK, 8'h0F, 1);
    for (int i = 0; i < 200 && m_timm() != 5; i++) step();
    rin_n = 1'b0; flp = 1'b0;
    step(); step();
    rin_n = 1'b1;
    chk("soft_rst_tsta", tsta, 0);
    io(1, PORT_TIM0, 8'h00, 1);
    io(1, PORT_TIM2, 8'h00, 1);
    chk("soft_rst_timm", last_rd, 8'h05);

    // Randomised traffic against the reference.
    for (int n = 0; n < 250; n++) begin
      int unsigned k, len;
      logic [7:0] a, d;
      k   = $urandom_range(0, 99);
      len = $urandom_range(1, 3);
      if (k < 45) begin
        a = rd_addrs[$urandom_range(0, 8)];
        io(1, a, 8'h00, len);
      end else if (k < 90) begin
        a = wr_addrs[$urandom_range(0, 6)];
        d = 8'($urandom_range(0, 255));
        if (a == PORT_ALM0) d = 8'($urandom_range(0, 12));
        if (a == PORT_ALM1 || a == PORT_ALM2) d = 8'h00;
        io(0, a, d, len);
      end else if (k < 95) begin
        restim = 1'b1;
        for (int unsigned i = 0; i < len; i++) step();
        restim = 1'b0;
      end
      for (int unsigned i = $urandom_range(0, 5); i > 0; i--) step();
    end

    step(); step();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_rtc.md
Name: blink_rtc

Overview:
Parametrised real-time clock and timer-interrupt unit for the Blink. It holds the tick prescaler, the TIM0–TIM4 counters, TSTA/TMK and a new minute alarm. It sits on the Blink I/O register bus and drives a single rtc_int into the interrupt combiner. Over the previous RTC logic it adds:
- generic rates and widths
- edge-qualified register accesses, so a side effect fires once per I/O cycle
- a coherent snapshot read of the multi-byte time
- an alarm interrupt

Parameters:
- TICK_DIV, 49152: mck cycles per tick (tick period is exactly TICK_DIV cycles).
- TICKS_PER_SEC, 200: ticks per second; tim0 range is 0..TICKS_PER_SEC-1.
- SEC_PER_MIN, 60: seconds per minute; tim1 range is 0..SEC_PER_MIN-1.
- MIN_W, 21: minute counter width, 17..24.
- ALARM_EN, 1: 0 removes the alarm logic; TSTA[3] then reads 0.

Ports:
- mck, in, 1: master clock; all logic on rising edge.
- rin_n, in, 1: reset, synchronous, active-low.
- flp, in, 1: flap; when flp=1 during reset, the reset is a hard reset.
- restim, in, 1: COM[4]; while 1, time counters are held at 0.
- ca, in, 8: I/O port address (Z80 A7..A0).
- cdi, in, 8: write data.
- ior_n, in, 1: I/O request, active-low.
- crd_n, in, 1: read strobe, active-low. ior_n=0 with crd_n=1 is a write.
- rdata, out, 8: registered read data.
- rhit, out, 1: 1 for one cycle after a decoded read.
- tsta, out, 4: status bits: tick, second, minute, alarm.
- rtc_int, out, 1: |(tsta & tmk).

Behaviour:
- Access qualification:
  - io_rd = !ior_n & !crd_n; io_wr = !ior_n & crd_n.
  - Both are registered (io_rd_d, io_wr_d). rd_p = io_rd & !io_rd_d; wr_p = io_wr & !io_wr_d.
  - Exactly one access per I/O cycle, however many mck cycles the strobe lasts. All side effects use rd_p / wr_p only.
- Reset (rin_n=0 at an edge):
  - rdata=0, rhit=0, tsta=0, tmk=0, alarm regs=0, alarm_armed=0, io_*_d=0.
  - Time counters (prescaler, tim0, tim1, timm, shadow) clear only if flp=1. With flp=0 they keep counting through reset.
- Counting (not restim, not hard reset):
  - The prescaler counts 0..TICK_DIV-1; the wrap cycle is the tick.
  - On tick: tim0 increments.
  - When tim0 wraps at TICKS_PER_SEC-1: tim1 increments.
  - When tim1 wraps at SEC_PER_MIN-1: timm increments, wrapping modulo 2^MIN_W silently.
  - All wraps occur in the same cycle as the tick.
  - restim=1 forces all counters to 0 every cycle. It does not touch tsta.
- Status set events, in the same cycle as the tick:
  - TSTA[0] sets on every tick.
  - TSTA[1] sets on a second wrap.
  - TSTA[2] sets on a minute wrap.
  - TSTA[3] sets when timm equals the alarm value on a minute wrap, with alarm_armed=1. alarm_armed then clears (one-shot).
- Status clear:
  - wr_p to $B4 clears each TSTA bit whose cdi bit is 1.
  - If set and clear coincide, set wins; the event is never lost.
- Writes (wr_p):
  - $B5: tmk <= cdi[3:0].
  - $D5/$D6/$D7: alarm bits 7:0 / 15:8 / MIN_W-1:16.
  - A write to $D7 sets alarm_armed=1. Writes to $D5/$D6 clear alarm_armed.
  - All other addresses are ignored.
- Reads (rd_p), result registered with 1-cycle latency; rhit=1 for that cycle; rdata holds until the next decoded read.
  - $B5: {4'b0, tsta}.
  - $D0: tim0. The same edge copies tim1 and timm into a shadow.
  - $D1: {2'b0, shadow tim1}.
  - $D2/$D3/$D4: shadow timm bytes 0/1/2, zero-padded above MIN_W.
  - Reads never change the counters or tsta.
  - Undecoded reads leave rdata unchanged with rhit=0.
- rtc_int is combinational from registered tsta/tmk. It is not latched here; the acknowledge path is via $B4.
- Width rules:
  - Prescaler width is clog2(TICK_DIV); tim0 and tim1 are 8 bits internally.
  - Elaboration fails if TICKS_PER_SEC>256, SEC_PER_MIN>64, or MIN_W is outside 17..24.

Decomposition:
- Package blink_pkg holds:
  - port address constants: PORT_TSTA=$B5, PORT_TACK=$B4, PORT_TMK=$B5, PORT_TIM0..4=$D0..$D4, PORT_ALM0..2=$D5..$D7
  - TSTA bit index constants
- Sub-module rtc_stat_bit: sticky status cell with set, clr, set-priority and synchronous reset. It is instantiated 4 times for TSTA[3:0].

Test Plan (TICK_DIV=4, TICKS_PER_SEC=3, SEC_PER_MIN=2, MIN_W=17):
- Reset with flp=1, then run 24 cycles:
  - tsta[0] sets at cycle 4.
  - tim0 reads 0,1,2,0.
  - tsta[1] sets at cycle 12; tsta[2] sets at cycle 24; timm=1.
- Hold a write to $B4 with cdi=$01 for 10 cycles while ticks occur:
  - tsta[0] clears once and re-sets on the next tick.
  - A tick that coincides with the clearing edge leaves tsta[0]=1.
- Set tmk=$02, wait for a second wrap:
  - rtc_int=1.
  - Write $B4 with $02: rtc_int=0 on the next cycle.
- Write alarm = 3 ($D5=$03, $D6=0, $D7=0), tmk=$08:
  - tsta[3] and rtc_int rise exactly when timm becomes 3.
  - After clearing, no re-fire when timm next returns to 3 (alarm disarmed).
- Snapshot coherency with timm=$00FF:
  - Read $D0 just before a minute wrap, then read $D2/$D3 after it.
  - Required result: $FF/$00, not $00/$01.
- Soft reset with flp=0 at timm=5:
  - tmk and tsta go to 0; timm stays 5 and keeps counting.
- restim=1 for 3 cycles: all counters read 0; tsta bits remain as they were.
